muldiv_unit: RTL and testbench

- Multi-cycle RV32M execution unit next to the single-cycle integer ALU.
- Takes one issued op from the reservation station and broadcasts the result, with its ROB tag, on a one-cycle CDB pulse.
- Multiply is a MUL_STAGES-deep pipeline that accepts one op per cycle.
- Divide/remainder is an iterative radix-2 restoring divider, one op at a time.

---
 rtl/muldiv_unit.sv | 194 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M multiply/divide unit beside the integer ALU, one result port onto the CDB.
// state | meaning
// IDLE  | divider free, a new op may be accepted
// RUN   | restoring iterations, one quotient bit per cycle
// FIX   | apply signs, select quotient or remainder, emit result
module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int TAG_W      = 4,
    parameter int MUL_STAGES = 3
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_v1,
    input  logic [XLEN-1:0]  in_v2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } div_state_e;

    div_state_e state_q;

    logic [MUL_STAGES-1:0] mul_v_q;
    logic [XLEN-1:0]       mul_r_q [MUL_STAGES];
    logic [TAG_W-1:0]      mul_t_q [MUL_STAGES];

    logic [XLEN-1:0]  quo_q, rem_q, dvs_q, cnt_q, div_res_q;
    logic             qneg_q, rneg_q, is_rem_q, div_v_q;
    logic [TAG_W-1:0] div_tag_q;
    logic [XLEN-1:0]  hold_r_q;
    logic [TAG_W-1:0] hold_t_q;

    logic mul_inflight, accept;

    assign mul_inflight = |mul_v_q;
    assign in_ready     = ~rst_in & ~flush_in & (state_q == S_IDLE) & ~(in_op[2] & mul_inflight);
    assign accept       = in_valid & in_ready & rdy_in;
    assign busy         = mul_inflight | (state_q != S_IDLE);

    // Operands widened to XLEN+1 so one signed multiply covers all four variants
    logic [XLEN:0]     mul_a, mul_b;
    logic [2*XLEN-1:0] mul_ea, mul_eb, mul_prod;

    assign mul_a    = {~(in_op[1] & in_op[0]) & in_v1[XLEN-1], in_v1};
    assign mul_b    = {~in_op[1] & in_v2[XLEN-1], in_v2};
    assign mul_ea   = {{(XLEN-1){mul_a[XLEN]}}, mul_a};
    assign mul_eb   = {{(XLEN-1){mul_b[XLEN]}}, mul_b};
    assign mul_prod = mul_ea * mul_eb;

    always_ff @(posedge clk_in) begin
        if (rst_in || flush_in) begin
            mul_v_q <= '0;
        end else if (rdy_in) begin
            mul_v_q[0] <= accept & ~in_op[2];
            for (int k = 1; k < MUL_STAGES; k++) begin
                mul_v_q[k] <= mul_v_q[k-1];
            end
        end
    end

    // The product is formed at entry; the trailing stages give retiming room.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            mul_r_q[0] <= (in_op[1:0] != 2'b00) ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];
            mul_t_q[0] <= in_tag;
            for (int k = 1; k < MUL_STAGES; k++) begin
                mul_r_q[k] <= mul_r_q[k-1];
                mul_t_q[k] <= mul_t_q[k-1];
            end
        end
    end

    logic            dv_sgn, dv_n1, dv_n2, dv_zero, dv_ovf;
    logic [XLEN-1:0] dv_mag1, dv_mag2;

    assign dv_sgn  = ~in_op[0];
    assign dv_n1   = dv_sgn & in_v1[XLEN-1];
    assign dv_n2   = dv_sgn & in_v2[XLEN-1];
    assign dv_mag1 = dv_n1 ? -in_v1 : in_v1;
    assign dv_mag2 = dv_n2 ? -in_v2 : in_v2;
    assign dv_zero = (in_v2 == '0);
    assign dv_ovf  = dv_sgn & (in_v1 == {1'b1, {(XLEN-1){1'b0}}}) & (&in_v2);

    logic [XLEN:0]   shifted, trial;
    logic [XLEN-1:0] rem_d, quo_d, quo_fix, rem_fix;

    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign trial   = shifted - {1'b0, dvs_q};
    assign rem_d   = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    assign quo_d   = {quo_q[XLEN-2:0], ~trial[XLEN]};
    assign quo_fix = qneg_q ? -quo_q : quo_q;
    assign rem_fix = rneg_q ? -rem_q : rem_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            div_v_q   <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            is_rem_q  <= 1'b0;
            div_tag_q <= '0;
            div_res_q <= '0;
        end else if (flush_in) begin
            state_q <= S_IDLE;
            div_v_q <= 1'b0;
        end else if (rdy_in) begin
            div_v_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept && in_op[2]) begin
                        is_rem_q  <= in_op[1];
                        div_tag_q <= in_tag;
                        dvs_q     <= dv_mag2;
                        cnt_q     <= XLEN'(XLEN);
                        // Special cases bypass the iterations and carry no sign fix-up
                        if (dv_zero) begin
                            quo_q   <= '1;
                            rem_q   <= in_v1;
                            qneg_q  <= 1'b0;
                            rneg_q  <= 1'b0;
                            state_q <= S_FIX;
                        end else if (dv_ovf) begin
                            quo_q   <= in_v1;
                            rem_q   <= '0;
                            qneg_q  <= 1'b0;
                            rneg_q  <= 1'b0;
                            state_q <= S_FIX;
                        end else begin
                            quo_q   <= dv_mag1;
                            rem_q   <= '0;
                            qneg_q  <= dv_n1 ^ dv_n2;
                            rneg_q  <= dv_n1;
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q - XLEN'(1);
                    if (cnt_q == XLEN'(1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    div_res_q <= is_rem_q ? rem_fix : quo_fix;
                    div_v_q   <= 1'b1;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic             res_v;
    logic [XLEN-1:0]  res_r;
    logic [TAG_W-1:0] res_t;

    assign res_v = mul_v_q[MUL_STAGES-1] | div_v_q;
    assign res_r = mul_v_q[MUL_STAGES-1] ? mul_r_q[MUL_STAGES-1] : div_res_q;
    assign res_t = mul_v_q[MUL_STAGES-1] ? mul_t_q[MUL_STAGES-1] : div_tag_q;

    // A result stalled by rdy_in stays in its register and is shown once rdy_in returns
    assign out_valid  = rdy_in & res_v;
    assign out_result = out_valid ? res_r : hold_r_q;
    assign out_tag    = out_valid ? res_t : hold_t_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hold_r_q <= '0;
            hold_t_q <= '0;
        end else if (out_valid) begin
            hold_r_q <= res_r;
            hold_t_q <= res_t;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed RV32M vectors with hand-computed results and latencies.
module tb_muldiv_unit;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in, in_valid;
    logic        in_ready, out_valid, busy;
    logic [2:0]  in_op;
    logic [31:0] in_v1, in_v2, out_result;
    logic [3:0]  in_tag, out_tag;

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    muldiv_unit #(.XLEN(32), .TAG_W(4), .MUL_STAGES(3)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .flush_in   (flush_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_v1      (in_v1),
        .in_v2      (in_v2),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_v1    = a;
        in_v2    = b;
        in_tag   = tag;
        #1;
        chk("in_ready_at_issue", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
    endtask

    // Entered in cycle T+1; returns in the cycle out_valid is seen (or the budget ran out)
    task automatic wait_valid(input int budget, output int n, output int rdy_hits);
        n        = 1;
        rdy_hits = 0;
        #1;
        while (out_valid !== 1'b1 && n < budget) begin
            if (in_ready === 1'b1) rdy_hits++;
            @(posedge clk_in);
            #2;
            n++;
        end
    endtask

    task automatic do_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag,
                         input logic [31:0] exp, input int lat, input bit chk_block);
        int n, hits;
        issue(op, a, b, tag);
        wait_valid(lat + 5, n, hits);
        chk({nm, "_latency"}, 32'(n), 32'(lat));
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_result"}, out_result, exp);
        chk({nm, "_tag"}, 32'(out_tag), 32'(tag));
        if (chk_block) begin
            chk({nm, "_ready_blocked"}, 32'(hits), 32'd0);
            chk({nm, "_ready_at_result"}, 32'(in_ready), 32'd1);
        end
        cyc();
    endtask

    task automatic quiet(input string nm, input int cycles);
        int hits = 0;
        for (int i = 0; i < cycles; i++) begin
            #1;
            if (out_valid === 1'b1) hits++;
            cyc();
        end
        chk(nm, 32'(hits), 32'd0);
    endtask

    logic [31:0] b2b_res [4] = '{32'd6, 32'd20, 32'd42, 32'd72};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in   = 1'b1;
        rdy_in   = 1'b1;
        flush_in = 1'b0;
        in_valid = 1'b0;
        in_op    = 3'd0;
        in_v1    = '0;
        in_v2    = '0;
        in_tag   = '0;
        cyc();
        cyc();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst_in = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        cyc();

        do_op("mul_7x-3",     3'b000, 32'd7,          32'hFFFF_FFFD, 4'd5, 32'hFFFF_FFEB, 3, 1'b0);
        do_op("mulhu_max",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6, 32'hFFFF_FFFE, 3, 1'b0);
        do_op("mulhsu_neg1",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd7, 32'hFFFF_FFFF, 3, 1'b0);
        do_op("mulh_min_sq",  3'b001, 32'h8000_0000, 32'h8000_0000, 4'd3, 32'h4000_0000, 3, 1'b0);

        // Four multiplies on consecutive cycles, results expected T+3..T+6 in tag order
        for (int c = 0; c < 8; c++) begin
            if (c < 4) begin
                in_valid = 1'b1;
                in_op    = 3'b000;
                in_v1    = 32'(2 * c + 2);
                in_v2    = 32'(2 * c + 3);
                in_tag   = 4'(c + 1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c < 4) chk("b2b_ready", 32'(in_ready), 32'd1);
            if (c >= 3 && c <= 6) begin
                chk("b2b_valid", 32'(out_valid), 32'd1);
                chk("b2b_tag", 32'(out_tag), 32'(c - 2));
                chk("b2b_result", out_result, b2b_res[c-3]);
            end else begin
                chk("b2b_idle", 32'(out_valid), 32'd0);
            end
            cyc();
        end

        do_op("div_-20_3",    3'b100, 32'hFFFF_FFEC, 32'd3,          4'd8, 32'hFFFF_FFFA, 34, 1'b1);
        do_op("rem_-20_3",    3'b110, 32'hFFFF_FFEC, 32'd3,          4'd9, 32'hFFFF_FFFE, 34, 1'b1);
        do_op("divu_8000_2",  3'b101, 32'h8000_0000, 32'd2,          4'd1, 32'h4000_0000, 34, 1'b1);
        do_op("div_20_-3",    3'b100, 32'd20,         32'hFFFF_FFFD, 4'd2, 32'hFFFF_FFFA, 34, 1'b0);
        do_op("rem_20_-3",    3'b110, 32'd20,         32'hFFFF_FFFD, 4'd3, 32'd2,         34, 1'b0);
        do_op("remu_100_7",   3'b111, 32'd100,        32'd7,          4'd4, 32'd2,         34, 1'b0);
        do_op("divu_by0",     3'b101, 32'h0000_1234, 32'd0,          4'd5, 32'hFFFF_FFFF, 2,  1'b1);
        do_op("rem_9_by0",    3'b110, 32'd9,          32'd0,          4'd6, 32'd9,         2,  1'b0);
        do_op("div_ovf",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 4'd7, 32'h8000_0000, 2,  1'b0);
        do_op("rem_ovf",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 4'd8, 32'd0,         2,  1'b0);

        // Divide presented behind two multiplies, then flushed at T+10
        issue(3'b000, 32'd3, 32'd4, 4'd9);
        in_valid = 1'b1;
        in_op    = 3'b000;
        in_v1    = 32'd5;
        in_v2    = 32'd6;
        in_tag   = 4'd10;
        #1;
        chk("hold_mul2_ready", 32'(in_ready), 32'd1);
        cyc();
        in_op  = 3'b100;
        in_v1  = 32'd100;
        in_v2  = 32'd7;
        in_tag = 4'd11;
        #1;
        chk("hold_div_ready_c2", 32'(in_ready), 32'd0);
        chk("hold_busy_c2", 32'(busy), 32'd1);
        cyc();
        #1;
        chk("hold_div_ready_c3", 32'(in_ready), 32'd0);
        chk("hold_mul1_valid", 32'(out_valid), 32'd1);
        chk("hold_mul1_tag", 32'(out_tag), 32'd9);
        chk("hold_mul1_result", out_result, 32'd12);
        cyc();
        #1;
        chk("hold_div_ready_c4", 32'(in_ready), 32'd0);
        chk("hold_mul2_valid", 32'(out_valid), 32'd1);
        chk("hold_mul2_tag", 32'(out_tag), 32'd10);
        chk("hold_mul2_result", out_result, 32'd30);
        cyc();
        #1;
        chk("hold_div_ready_c5", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        repeat (9) cyc();
        flush_in = 1'b1;
        #1;
        chk("flush_blocks_ready", 32'(in_ready), 32'd0);
        cyc();
        flush_in = 1'b0;
        #1;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        quiet("flush_no_result", 40);

        // rdy_in low for T+3..T+5 covering the multiply's completion cycle
        issue(3'b000, 32'd11, 32'd13, 4'd12);
        cyc();
        for (int c = 3; c <= 5; c++) begin
            cyc();
            rdy_in = 1'b0;
            #1;
            chk("stall_no_valid", 32'(out_valid), 32'd0);
        end
        cyc();
        rdy_in = 1'b1;
        #1;
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_result", out_result, 32'd143);
        chk("stall_tag", 32'(out_tag), 32'd12);
        cyc();
        #1;
        chk("stall_single_pulse", 32'(out_valid), 32'd0);
        chk("stall_result_held", out_result, 32'd143);
        chk("stall_tag_held", 32'(out_tag), 32'd12);
        cyc();

        // Reset in the middle of a divide
        issue(3'b100, 32'd100, 32'd7, 4'd13);
        repeat (4) cyc();
        rst_in = 1'b1;
        cyc();
        rst_in = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_result", out_result, 32'd0);
        chk("midrst_out_tag", 32'(out_tag), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        quiet("midrst_no_result", 40);

        do_op("mul_after_rst", 3'b000, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 4'd14, 32'd25, 3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
